// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// Module      : y86_pkg
// Description : Shared Y86-64 decode constants: instruction codes, register
//               identifiers, E-register reset/bubble image, index helper.
// Revision    : 1.0 - first pipelined decode with register file
// ============================================================================
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Register identifiers
  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  // Control half of the D->E pipeline register
  typedef struct packed {
    logic       valid;
    logic [3:0] icode;
    logic [3:0] srcA;
    logic [3:0] srcB;
    logic [3:0] dstE;
    logic [3:0] dstM;
  } e_ctrl_t;

  // Image loaded on reset and on a bubble: an invalid nop touching nothing
  localparam e_ctrl_t E_CTRL_RST = '{
    valid: 1'b0,
    icode: INOP,
    srcA:  RNONE,
    srcB:  RNONE,
    dstE:  RNONE,
    dstM:  RNONE
  };

  // True when an index names a physically implemented register
  function automatic logic idx_ok(input logic [3:0] idx, input int nreg);
    return (idx != RNONE) && (int'({28'd0, idx}) < nreg);
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_core.sv
`default_nettype none
// ============================================================================
// Module      : regfile_core
// Description : NREG x DATA_W register file, two asynchronous read ports and
//               two write ports. The M port wins when both write one index.
//               Optional same-cycle write->read bypass under the macro
//               REGFILE_BYPASS_EN (M data preferred over E data).
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_core
  import y86_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int NREG   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        rd_a_idx_i,
  input  logic [3:0]        rd_b_idx_i,
  output logic [DATA_W-1:0] rd_a_data_o,
  output logic [DATA_W-1:0] rd_b_data_o,
  input  logic [3:0]        wr_e_idx_i,
  input  logic [DATA_W-1:0] wr_e_data_i,
  input  logic [3:0]        wr_m_idx_i,
  input  logic [DATA_W-1:0] wr_m_data_i
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic              wr_e_en;
  logic              wr_m_en;

  // Indices of RNONE or beyond the implemented range never write
  assign wr_e_en = idx_ok(wr_e_idx_i, NREG);
  assign wr_m_en = idx_ok(wr_m_idx_i, NREG);

  // Storage update; M is tested first so it takes a shared index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wr_m_en && (wr_m_idx_i == 4'(i)))      regs_q[i] <= wr_m_data_i;
        else if (wr_e_en && (wr_e_idx_i == 4'(i))) regs_q[i] <= wr_e_data_i;
      end
    end
  end

  // Read muxes; unmatched indices (RNONE, out of range) read as zero
  always_comb begin
    rd_a_data_o = '0;
    rd_b_data_o = '0;
    for (int i = 0; i < NREG; i++) begin
      if (rd_a_idx_i == 4'(i)) rd_a_data_o = regs_q[i];
      if (rd_b_idx_i == 4'(i)) rd_b_data_o = regs_q[i];
    end
`ifdef REGFILE_BYPASS_EN
    // Forward in-flight write data; M assigned last so it overrides E
    if (wr_e_en && (wr_e_idx_i == rd_a_idx_i)) rd_a_data_o = wr_e_data_i;
    if (wr_e_en && (wr_e_idx_i == rd_b_idx_i)) rd_b_data_o = wr_e_data_i;
    if (wr_m_en && (wr_m_idx_i == rd_a_idx_i)) rd_a_data_o = wr_m_data_i;
    if (wr_m_en && (wr_m_idx_i == rd_b_idx_i)) rd_b_data_o = wr_m_data_i;
`endif
  end

endmodule
`default_nettype wire

// File: rtl/decode_stage_rf.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_rf
// Description : Y86-64 decode stage. Selects source/destination registers
//               from icode, reads the register file (written directly by
//               write-back) and captures the result in the D->E pipeline
//               register with bubble-over-stall control.
//               Optional macro: REGFILE_BYPASS_EN (same-cycle write bypass).
// Revision    : 1.0 - replaces the combinational-only decode
// ============================================================================
module decode_stage_rf
  import y86_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int NREG   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              D_valid_i,
  input  logic [3:0]        D_icode_i,
  input  logic [3:0]        D_rA_i,
  input  logic [3:0]        D_rB_i,
  input  logic              stall_E_i,
  input  logic              bubble_E_i,
  input  logic [3:0]        W_dstE_i,
  input  logic [DATA_W-1:0] W_valE_i,
  input  logic [3:0]        W_dstM_i,
  input  logic [DATA_W-1:0] W_valM_i,
  output logic              E_valid_o,
  output logic [3:0]        E_icode_o,
  output logic [3:0]        E_srcA_o,
  output logic [3:0]        E_srcB_o,
  output logic [3:0]        E_dstE_o,
  output logic [3:0]        E_dstM_o,
  output logic [DATA_W-1:0] E_valA_o,
  output logic [DATA_W-1:0] E_valB_o
);

  logic [3:0]        sel_srcA;
  logic [3:0]        sel_srcB;
  logic [3:0]        sel_dstE;
  logic [3:0]        sel_dstM;
  logic [DATA_W-1:0] rd_valA;
  logic [DATA_W-1:0] rd_valB;

  e_ctrl_t           e_ctrl_q, e_ctrl_d;
  logic [DATA_W-1:0] e_valA_q, e_valA_d;
  logic [DATA_W-1:0] e_valB_q, e_valB_d;

  // Operand/destination selection by instruction class
  always_comb begin
    sel_srcA = RNONE;
    sel_srcB = RNONE;
    sel_dstE = RNONE;
    sel_dstM = RNONE;
    if (D_valid_i) begin
      case (D_icode_i)
        IRRMOVQ: begin sel_srcA = D_rA_i; sel_dstE = D_rB_i; end
        IIRMOVQ: begin sel_dstE = D_rB_i; end
        IRMMOVQ: begin sel_srcA = D_rA_i; sel_srcB = D_rB_i; end
        IMRMOVQ: begin sel_srcB = D_rB_i; sel_dstM = D_rA_i; end
        IOPQ:    begin sel_srcA = D_rA_i; sel_srcB = D_rB_i; sel_dstE = D_rB_i; end
        ICALL:   begin sel_srcB = RSP;    sel_dstE = RSP; end
        IRET:    begin sel_srcA = RSP;    sel_srcB = RSP;    sel_dstE = RSP; end
        IPUSHQ:  begin sel_srcA = D_rA_i; sel_srcB = RSP;    sel_dstE = RSP; end
        IPOPQ:   begin
          sel_srcA = RSP;
          sel_srcB = RSP;
          sel_dstE = RSP;
          sel_dstM = D_rA_i;
        end
        default: ;
      endcase
    end
  end

  regfile_core #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_regfile (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_a_idx_i  (sel_srcA),
    .rd_b_idx_i  (sel_srcB),
    .rd_a_data_o (rd_valA),
    .rd_b_data_o (rd_valB),
    .wr_e_idx_i  (W_dstE_i),
    .wr_e_data_i (W_valE_i),
    .wr_m_idx_i  (W_dstM_i),
    .wr_m_data_i (W_valM_i)
  );

  // Next E contents: bubble beats stall, stall holds, otherwise load decode
  always_comb begin
    e_ctrl_d = e_ctrl_q;
    e_valA_d = e_valA_q;
    e_valB_d = e_valB_q;
    if (bubble_E_i) begin
      e_ctrl_d = E_CTRL_RST;
      e_valA_d = '0;
      e_valB_d = '0;
    end else if (!stall_E_i) begin
      e_ctrl_d = '{valid: D_valid_i, icode: D_icode_i, srcA: sel_srcA,
                   srcB: sel_srcB, dstE: sel_dstE, dstM: sel_dstM};
      e_valA_d = rd_valA;
      e_valB_d = rd_valB;
    end
  end

  // D->E pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_ctrl_q <= E_CTRL_RST;
      e_valA_q <= '0;
      e_valB_q <= '0;
    end else begin
      e_ctrl_q <= e_ctrl_d;
      e_valA_q <= e_valA_d;
      e_valB_q <= e_valB_d;
    end
  end

  assign E_valid_o = e_ctrl_q.valid;
  assign E_icode_o = e_ctrl_q.icode;
  assign E_srcA_o  = e_ctrl_q.srcA;
  assign E_srcB_o  = e_ctrl_q.srcB;
  assign E_dstE_o  = e_ctrl_q.dstE;
  assign E_dstM_o  = e_ctrl_q.dstM;
  assign E_valA_o  = e_valA_q;
  assign E_valB_o  = e_valB_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_rf.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage_rf
// Description : Self-checking bench for decode_stage_rf. Drives a default
//               (NREG=15) and a reduced (NREG=8) instance from the same
//               stimulus. Expected bypass behaviour follows REGFILE_BYPASS_EN.
// Revision    : 1.0
// ============================================================================
module tb_decode_stage_rf;

  localparam int DW = 64;

  typedef struct {
    logic        v;
    logic [3:0]  ic, sa, sb, de, dm;
    logic [63:0] va, vb;
  } exp_t;

  typedef struct {
    logic       v;
    logic [3:0] ic, ra, rb;
    logic [3:0] sa, sb, de, dm;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          D_valid;
  logic [3:0]    D_icode, D_rA, D_rB;
  logic          stall_E, bubble_E;
  logic [3:0]    W_dstE, W_dstM;
  logic [DW-1:0] W_valE, W_valM;

  logic          E_valid, E8_valid;
  logic [3:0]    E_icode, E_srcA, E_srcB, E_dstE, E_dstM;
  logic [3:0]    E8_icode, E8_srcA, E8_srcB, E8_dstE, E8_dstM;
  logic [DW-1:0] E_valA, E_valB, E8_valA, E8_valB;

  decode_stage_rf #(.DATA_W(DW), .NREG(15)) dut (
    .clk(clk), .rst_n(rst_n), .D_valid_i(D_valid), .D_icode_i(D_icode),
    .D_rA_i(D_rA), .D_rB_i(D_rB), .stall_E_i(stall_E), .bubble_E_i(bubble_E),
    .W_dstE_i(W_dstE), .W_valE_i(W_valE), .W_dstM_i(W_dstM), .W_valM_i(W_valM),
    .E_valid_o(E_valid), .E_icode_o(E_icode), .E_srcA_o(E_srcA), .E_srcB_o(E_srcB),
    .E_dstE_o(E_dstE), .E_dstM_o(E_dstM), .E_valA_o(E_valA), .E_valB_o(E_valB)
  );

  decode_stage_rf #(.DATA_W(DW), .NREG(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .D_valid_i(D_valid), .D_icode_i(D_icode),
    .D_rA_i(D_rA), .D_rB_i(D_rB), .stall_E_i(stall_E), .bubble_E_i(bubble_E),
    .W_dstE_i(W_dstE), .W_valE_i(W_valE), .W_dstM_i(W_dstM), .W_valM_i(W_valM),
    .E_valid_o(E8_valid), .E_icode_o(E8_icode), .E_srcA_o(E8_srcA), .E_srcB_o(E8_srcB),
    .E_dstE_o(E8_dstE), .E_dstM_o(E8_dstM), .E_valA_o(E8_valA), .E_valB_o(E8_valB)
  );

  int total = 0;
  int bad   = 0;

  // Reference state: architectural register arrays and expected E contents
  logic [15:0][63:0] m15, m8;
  exp_t              e15, e8;
  exp_t              ERST;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model (instruction-level view) ----------------
  function automatic logic [3:0] f_srcA(input logic v, input logic [3:0] ic, input logic [3:0] ra);
    if (!v) return 4'hF;
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
    if (ic inside {4'h9, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] f_srcB(input logic v, input logic [3:0] ic, input logic [3:0] rb);
    if (!v) return 4'hF;
    if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] f_dstE(input logic v, input logic [3:0] ic, input logic [3:0] rb);
    if (!v) return 4'hF;
    if (ic inside {4'h2, 4'h3, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] f_dstM(input logic v, input logic [3:0] ic, input logic [3:0] ra);
    if (!v) return 4'hF;
    if (ic inside {4'h5, 4'hB}) return ra;
    return 4'hF;
  endfunction

  function automatic logic [63:0] m_read(input logic [15:0][63:0] rf, input int nreg,
                                         input logic [3:0] idx);
    logic [63:0] v;
    if (idx == 4'hF || int'({28'd0, idx}) >= nreg) return 64'd0;
    v = rf[idx];
`ifdef REGFILE_BYPASS_EN
    if (W_dstE == idx) v = W_valE;
    if (W_dstM == idx) v = W_valM;
`endif
    return v;
  endfunction

  function automatic logic [15:0][63:0] m_write(input logic [15:0][63:0] rf, input int nreg);
    logic [15:0][63:0] r;
    r = rf;
    if (W_dstE != 4'hF && int'({28'd0, W_dstE}) < nreg) r[W_dstE] = W_valE;
    if (W_dstM != 4'hF && int'({28'd0, W_dstM}) < nreg) r[W_dstM] = W_valM;
    return r;
  endfunction

  function automatic exp_t m_next(input exp_t cur, input logic [15:0][63:0] rf, input int nreg);
    exp_t n;
    if (bubble_E) return ERST;
    if (stall_E) return cur;
    n.v  = D_valid;
    n.ic = D_icode;
    n.sa = f_srcA(D_valid, D_icode, D_rA);
    n.sb = f_srcB(D_valid, D_icode, D_rB);
    n.de = f_dstE(D_valid, D_icode, D_rB);
    n.dm = f_dstM(D_valid, D_icode, D_rA);
    n.va = m_read(rf, nreg, n.sa);
    n.vb = m_read(rf, nreg, n.sb);
    return n;
  endfunction

  // One clock with the currently driven inputs; model advances with the DUT
  task automatic step();
    exp_t n15, n8;
    n15 = m_next(e15, m15, 15);
    n8  = m_next(e8, m8, 8);
    @(posedge clk);
    e15 = n15;
    e8  = n8;
    m15 = m_write(m15, 15);
    m8  = m_write(m8, 8);
    #1;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".valid"}, 64'(E_valid), 64'(e15.v));
    chk({tag, ".icode"}, 64'(E_icode), 64'(e15.ic));
    chk({tag, ".srcA"},  64'(E_srcA),  64'(e15.sa));
    chk({tag, ".srcB"},  64'(E_srcB),  64'(e15.sb));
    chk({tag, ".dstE"},  64'(E_dstE),  64'(e15.de));
    chk({tag, ".dstM"},  64'(E_dstM),  64'(e15.dm));
    chk({tag, ".valA"},  E_valA,       e15.va);
    chk({tag, ".valB"},  E_valB,       e15.vb);
    chk({tag, ".n8.icode"}, 64'(E8_icode), 64'(e8.ic));
    chk({tag, ".n8.dstE"},  64'(E8_dstE),  64'(e8.de));
    chk({tag, ".n8.valA"},  E8_valA,       e8.va);
    chk({tag, ".n8.valB"},  E8_valB,       e8.vb);
  endtask

  task automatic drive_d(input logic v, input logic [3:0] ic, input logic [3:0] ra,
                         input logic [3:0] rb);
    D_valid = v; D_icode = ic; D_rA = ra; D_rB = rb;
  endtask

  task automatic drive_w(input logic [3:0] de, input logic [63:0] ve,
                         input logic [3:0] dm, input logic [63:0] vm);
    W_dstE = de; W_valE = ve; W_dstM = dm; W_valM = vm;
  endtask

  // Asynchronous reset pulse asserted between clock edges
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    m15 = '0; m8 = '0; e15 = ERST; e8 = ERST;
    compare_all("reset_async");
    @(posedge clk);
    #1 compare_all("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t vt[13];

  initial begin
    ERST = '{v: 1'b0, ic: 4'h1, sa: 4'hF, sb: 4'hF, de: 4'hF, dm: 4'hF, va: 64'd0, vb: 64'd0};
    rst_n = 1'b1;
    stall_E = 1'b0; bubble_E = 1'b0;
    drive_d(1'b0, 4'h1, 4'hF, 4'hF);
    drive_w(4'hF, 64'd0, 4'hF, 64'd0);
    m15 = '0; m8 = '0; e15 = ERST; e8 = ERST;

    do_reset();

    // ---- selection table: rA=1, rB=2, empty register file ----
    vt[0]  = '{1'b1, 4'h0, 4'h1, 4'h2, 4'hF, 4'hF, 4'hF, 4'hF};
    vt[1]  = '{1'b1, 4'h1, 4'h1, 4'h2, 4'hF, 4'hF, 4'hF, 4'hF};
    vt[2]  = '{1'b1, 4'h2, 4'h1, 4'h2, 4'h1, 4'hF, 4'h2, 4'hF};
    vt[3]  = '{1'b1, 4'h3, 4'h1, 4'h2, 4'hF, 4'hF, 4'h2, 4'hF};
    vt[4]  = '{1'b1, 4'h4, 4'h1, 4'h2, 4'h1, 4'h2, 4'hF, 4'hF};
    vt[5]  = '{1'b1, 4'h5, 4'h1, 4'h2, 4'hF, 4'h2, 4'hF, 4'h1};
    vt[6]  = '{1'b1, 4'h6, 4'h1, 4'h2, 4'h1, 4'h2, 4'h2, 4'hF};
    vt[7]  = '{1'b1, 4'h7, 4'h1, 4'h2, 4'hF, 4'hF, 4'hF, 4'hF};
    vt[8]  = '{1'b1, 4'h8, 4'h1, 4'h2, 4'hF, 4'h4, 4'h4, 4'hF};
    vt[9]  = '{1'b1, 4'h9, 4'h1, 4'h2, 4'h4, 4'h4, 4'h4, 4'hF};
    vt[10] = '{1'b1, 4'hA, 4'h1, 4'h2, 4'h1, 4'h4, 4'h4, 4'hF};
    vt[11] = '{1'b1, 4'hB, 4'h1, 4'h2, 4'h4, 4'h4, 4'h4, 4'h1};
    vt[12] = '{1'b0, 4'h6, 4'h1, 4'h2, 4'hF, 4'hF, 4'hF, 4'hF};
    for (int i = 0; i < 13; i++) begin
      drive_d(vt[i].v, vt[i].ic, vt[i].ra, vt[i].rb);
      step();
      chk($sformatf("tbl%0d.valid", i), 64'(E_valid), 64'(vt[i].v));
      chk($sformatf("tbl%0d.icode", i), 64'(E_icode), 64'(vt[i].ic));
      chk($sformatf("tbl%0d.srcA", i),  64'(E_srcA),  64'(vt[i].sa));
      chk($sformatf("tbl%0d.srcB", i),  64'(E_srcB),  64'(vt[i].sb));
      chk($sformatf("tbl%0d.dstE", i),  64'(E_dstE),  64'(vt[i].de));
      chk($sformatf("tbl%0d.dstM", i),  64'(E_dstM),  64'(vt[i].dm));
      chk($sformatf("tbl%0d.valA", i),  E_valA,       64'd0);
    end

    // ---- irmovq write then OPq read ----
    drive_d(1'b1, 4'h3, 4'hF, 4'h2);
    drive_w(4'h2, 64'h1234, 4'hF, 64'd0);
    step();
    drive_d(1'b1, 4'h6, 4'h2, 4'h3);
    drive_w(4'hF, 64'd0, 4'hF, 64'd0);
    step();
    chk("opq.valA", E_valA, 64'h1234);
    chk("opq.srcA", 64'(E_srcA), 64'h2);
    chk("opq.dstE", 64'(E_dstE), 64'h3);
    chk("opq.valB", E_valB, 64'd0);
    chk("opq.n8.valA", E8_valA, 64'h1234);

    // ---- popq: both ports hit %rsp, M wins ----
    drive_d(1'b1, 4'hB, 4'h4, 4'hF);
    drive_w(4'h4, 64'h100, 4'h4, 64'h55);
    step();
    drive_d(1'b1, 4'h9, 4'hF, 4'hF);
    drive_w(4'hF, 64'd0, 4'hF, 64'd0);
    step();
    chk("ret.valA", E_valA, 64'h55);
    chk("ret.valB", E_valB, 64'h55);

    // ---- stall holds E for two cycles, then bubble overrides stall ----
    stall_E = 1'b1;
    drive_d(1'b1, 4'h6, 4'h2, 4'h3);
    step();
    drive_d(1'b1, 4'h2, 4'h1, 4'h5);
    step();
    chk("stall.valid", 64'(E_valid), 64'd1);
    chk("stall.icode", 64'(E_icode), 64'h9);
    chk("stall.srcA",  64'(E_srcA),  64'h4);
    chk("stall.valA",  E_valA,       64'h55);
    bubble_E = 1'b1;
    step();
    chk("bubble.icode", 64'(E_icode), 64'h1);
    chk("bubble.valid", 64'(E_valid), 64'd0);
    chk("bubble.dstE",  64'(E_dstE),  64'hF);
    chk("bubble.valA",  E_valA,       64'd0);
    stall_E = 1'b0; bubble_E = 1'b0;

    // ---- same-cycle write and read of register 7 ----
    drive_d(1'b1, 4'h2, 4'h7, 4'h1);
    drive_w(4'h7, 64'hAA, 4'hF, 64'd0);
    step();
`ifdef REGFILE_BYPASS_EN
    chk("bypass.valA", E_valA, 64'hAA);
`else
    chk("bypass.valA", E_valA, 64'd0);
`endif
    drive_w(4'hF, 64'd0, 4'hF, 64'd0);
    step();
    chk("after_wr.valA", E_valA, 64'hAA);

    // ---- out-of-range write on the NREG=8 instance ----
    drive_d(1'b1, 4'h1, 4'hF, 4'hF);
    drive_w(4'h9, 64'hFF, 4'hF, 64'd0);
    step();
    drive_d(1'b1, 4'h2, 4'h9, 4'h0);
    drive_w(4'hF, 64'd0, 4'hF, 64'd0);
    step();
    chk("n8.oor.valA", E8_valA, 64'd0);
    chk("n15.r9.valA", E_valA, 64'hFF);
    drive_d(1'b1, 4'h6, 4'h1, 4'h0);
    step();
    chk("n8.r1_untouched", E8_valA, 64'd0);
    chk("n8.r0_untouched", E8_valB, 64'd0);

    // ---- reset mid-stream, then every register reads zero ----
    drive_w(4'h3, 64'hDEAD, 4'h5, 64'hBEEF);
    do_reset();
    drive_w(4'hF, 64'd0, 4'hF, 64'd0);
    for (int r = 0; r < 15; r++) begin
      drive_d(1'b1, 4'h6, 4'(r), 4'(r));
      step();
      chk($sformatf("post_rst.r%0d.valA", r), E_valA, 64'd0);
      chk($sformatf("post_rst.r%0d.valB", r), E_valB, 64'd0);
    end

    // ---- randomized run against the reference model ----
    for (int c = 0; c < 600; c++) begin
      logic [3:0] de;
      drive_d($urandom_range(0, 9) != 0, 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      stall_E  = ($urandom_range(0, 5) == 0);
      bubble_E = ($urandom_range(0, 7) == 0);
      de = 4'($urandom_range(0, 15));
      drive_w(de, {$urandom, $urandom},
              ($urandom_range(0, 3) == 0) ? de : 4'($urandom_range(0, 15)),
              {$urandom, $urandom});
      if (c == 300) do_reset();
      step();
      compare_all($sformatf("rnd%0d", c));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
